// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: registers a decoded instruction, maps ALUOp/opcode to an
// ALU select, and resolves EX/MEM and MEM/WB forwarding onto the A/B operands.
module id_ex_operand_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [10:0]      opcode,
  input  logic             alu_src,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] imm,
  input  logic             flush,
  input  logic             out_ready,
  input  logic             exm_wr_en,
  input  logic [4:0]       exm_rd,
  input  logic [WIDTH-1:0] exm_result,
  input  logic             wb_wr_en,
  input  logic [4:0]       wb_rd,
  input  logic [WIDTH-1:0] wb_result,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  output logic [WIDTH-1:0] store_data,
  output logic [4:0]       ex_rd,
  output logic             illegal
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;

  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_BAD = 4'b1111;

  localparam logic [4:0] XZR = 5'd31;

  state_t           state;
  logic [3:0]       held_sel;
  logic             held_src;
  logic [4:0]       held_rs1;
  logic [4:0]       held_rs2;
  logic [4:0]       held_rd;
  logic [WIDTH-1:0] held_rs1_data;
  logic [WIDTH-1:0] held_rs2_data;
  logic [WIDTH-1:0] held_imm;
  logic             held_illegal;

  logic [3:0]       dec_sel;
  logic             dec_illegal;
  logic             capture;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    dec_sel     = SEL_BAD;
    dec_illegal = 1'b1;
    unique case (alu_op)
      2'b00: begin
        dec_sel     = SEL_ADD;
        dec_illegal = 1'b0;
      end
      2'b01: begin
        dec_sel     = SEL_SUB;
        dec_illegal = 1'b0;
      end
      2'b10: begin
        dec_illegal = 1'b0;
        case (opcode)
          OPC_ADD: dec_sel = SEL_ADD;
          OPC_SUB: dec_sel = SEL_SUB;
          OPC_AND: dec_sel = SEL_AND;
          OPC_ORR: dec_sel = SEL_OR;
          default: begin
            dec_sel     = SEL_BAD;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_sel     = SEL_BAD;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // EX/MEM is the younger producer, so it is checked first; XZR is never forwarded.
  function automatic logic [WIDTH-1:0] forward(
    input logic [4:0]       rs,
    input logic [WIDTH-1:0] held,
    input logic             e_en,
    input logic [4:0]       e_rd,
    input logic [WIDTH-1:0] e_res,
    input logic             w_en,
    input logic [4:0]       w_rd,
    input logic [WIDTH-1:0] w_res
  );
    if (rs == XZR)                  return held;
    else if (e_en && (e_rd == rs))  return e_res;
    else if (w_en && (w_rd == rs))  return w_res;
    else                            return held;
  endfunction

  assign fwd_a = forward(held_rs1, held_rs1_data, exm_wr_en, exm_rd, exm_result,
                         wb_wr_en, wb_rd, wb_result);
  assign fwd_b = forward(held_rs2, held_rs2_data, exm_wr_en, exm_rd, exm_result,
                         wb_wr_en, wb_rd, wb_result);

  assign out_valid  = (state == FULL);
  assign in_ready   = !out_valid || out_ready;
  assign capture    = in_valid && in_ready;

  assign alu_a      = fwd_a;
  assign store_data = fwd_b;
  assign alu_b      = held_src ? held_imm : fwd_b;
  assign alu_sel    = held_sel;
  assign ex_rd      = held_rd;
  assign illegal    = held_illegal;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= EMPTY;
      held_sel      <= SEL_AND;
      held_src      <= 1'b0;
      held_rs1      <= '0;
      held_rs2      <= '0;
      held_rd       <= '0;
      held_rs1_data <= '0;
      held_rs2_data <= '0;
      held_imm      <= '0;
      held_illegal  <= 1'b0;
    end else if (flush) begin
      // Squash wins over a simultaneous capture; the incoming instruction is dropped.
      state        <= EMPTY;
      held_illegal <= 1'b0;
    end else if (capture) begin
      state         <= FULL;
      held_sel      <= dec_sel;
      held_src      <= alu_src;
      held_rs1      <= rs1;
      held_rs2      <= rs2;
      held_rd       <= rd;
      held_rs1_data <= rs1_data;
      held_rs2_data <= rs2_data;
      held_imm      <= imm;
      held_illegal  <= dec_illegal;
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed scenarios then random traffic,
// with a monitor comparing each presented instruction against a reference model.
module tb_id_ex_operand_stage;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, alu_src, flush, out_ready;
  logic [1:0]    alu_op;
  logic [10:0]   opcode;
  logic [4:0]    rs1, rs2, rd, exm_rd, wb_rd, ex_rd;
  logic [W-1:0]  rs1_data, rs2_data, imm, exm_result, wb_result;
  logic          exm_wr_en, wb_wr_en, out_valid, illegal;
  logic [W-1:0]  alu_a, alu_b, store_data;
  logic [3:0]    alu_sel;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .opcode(opcode), .alu_src(alu_src),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .flush(flush), .out_ready(out_ready),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_result(wb_result),
    .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .store_data(store_data), .ex_rd(ex_rd), .illegal(illegal)
  );

  typedef struct {
    logic [3:0]   sel;
    logic         ill;
    logic         src;
    logic [4:0]   rs1, rs2, rd;
    logic [W-1:0] d1, d2, imm;
  } item_t;

  item_t q[$];
  bit    m_full = 1'b0;
  int    checks = 0;
  int    errors = 0;

  localparam logic [10:0] ADD = 11'b10001011000;
  localparam logic [10:0] SUB = 11'b11001011000;
  localparam logic [10:0] AND = 11'b10001010000;
  localparam logic [10:0] ORR = 11'b10101010000;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {illegal, alu_sel} from the ALUOp / opcode table.
  function automatic logic [4:0] ref_decode(input logic [1:0] op, input logic [10:0] opc);
    if (op == 2'b00) return 5'b0_0010;
    if (op == 2'b01) return 5'b0_0110;
    if (op == 2'b10) begin
      if (opc == ADD) return 5'b0_0010;
      if (opc == SUB) return 5'b0_0110;
      if (opc == AND) return 5'b0_0000;
      if (opc == ORR) return 5'b0_0001;
    end
    return 5'b1_1111;
  endfunction

  function automatic logic [W-1:0] ref_operand(input logic [4:0] r, input logic [W-1:0] held);
    if (r == 5'd31) return held;
    if (exm_wr_en && exm_rd == r) return exm_result;
    if (wb_wr_en && wb_rd == r) return wb_result;
    return held;
  endfunction

  // Clock edge: advance the model from the inputs the DUT just sampled.
  task automatic tick();
    item_t it;
    logic  cap;
    logic [4:0] d;
    @(posedge clk);
    if (rst_n) begin
      cap = in_valid && (!m_full || out_ready);
      if (flush) begin
        q.delete();
        m_full = 1'b0;
      end else if (cap) begin
        d      = ref_decode(alu_op, opcode);
        it.ill = d[4];
        it.sel = d[3:0];
        it.src = alu_src;
        it.rs1 = rs1; it.rs2 = rs2; it.rd = rd;
        it.d1  = rs1_data; it.d2 = rs2_data; it.imm = imm;
        q.push_back(it);
        m_full = 1'b1;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
    end
    #1;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [10:0] opc, input logic src,
                           input logic [4:0] a, input logic [4:0] b, input logic [4:0] dst,
                           input logic [W-1:0] da, input logic [W-1:0] db,
                           input logic [W-1:0] im);
    alu_op = op; opcode = opc; alu_src = src;
    rs1 = a; rs2 = b; rd = dst;
    rs1_data = da; rs2_data = db; imm = im;
  endtask

  task automatic clear_wb();
    exm_wr_en = 1'b0; exm_rd = '0; exm_result = '0;
    wb_wr_en  = 1'b0; wb_rd  = '0; wb_result  = '0;
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", out_valid, m_full);
      check("in_ready", in_ready, !m_full || out_ready);
      if (out_valid && q.size() > 0) begin
        check("alu_sel", alu_sel, q[0].sel);
        check("illegal", illegal, q[0].ill);
        check("ex_rd", ex_rd, q[0].rd);
        check("alu_a", alu_a, ref_operand(q[0].rs1, q[0].d1));
        check("store_data", store_data, ref_operand(q[0].rs2, q[0].d2));
        check("alu_b", alu_b, q[0].src ? q[0].imm : ref_operand(q[0].rs2, q[0].d2));
        if (out_ready && !flush) void'(q.pop_front());
      end
    end
  end

  function automatic logic [4:0] pick_reg();
    logic [4:0] regs [5];
    regs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};
    return regs[$urandom_range(0, 4)];
  endfunction

  function automatic logic [10:0] pick_opc();
    case ($urandom_range(0, 5))
      0: return ADD;
      1: return SUB;
      2: return AND;
      3: return ORR;
      4: return 11'h7FF;
      default: return 11'($urandom);
    endcase
  endfunction

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    set_instr(2'b00, '0, 1'b0, '0, '0, '0, '0, '0, '0);
    clear_wb();
    #2;
    check("rst out_valid", out_valid, 1'b0);
    check("rst alu_sel", alu_sel, 4'b0000);
    check("rst illegal", illegal, 1'b0);
    check("rst ex_rd", ex_rd, 5'd0);
    check("rst alu_a", alu_a, '0);
    check("rst alu_b", alu_b, '0);
    check("rst in_ready", in_ready, 1'b1);
    tick(); tick();
    rst_n = 1'b1;

    // R-type ADD
    set_instr(2'b10, ADD, 1'b0, 5'd1, 5'd2, 5'd4, 64'd5, 64'd7, 64'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("add alu_a", alu_a, 64'd5);
    check("add alu_b", alu_b, 64'd7);
    check("add alu_sel", alu_sel, 4'b0010);
    tick();

    // Load address with negative immediate
    set_instr(2'b00, '0, 1'b1, 5'd2, 5'd3, 5'd5, 64'h100, 64'h55, 64'hFFFF_FFFF_FFFF_FFF8);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ld alu_b", alu_b, 64'hFFFF_FFFF_FFFF_FFF8);
    check("ld alu_a", alu_a, 64'h100);
    tick();

    // Forwarding priority on a held SUB, then XZR
    set_instr(2'b10, SUB, 1'b0, 5'd3, 5'd4, 5'd9, 64'h11, 64'h22, 64'd0);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    exm_wr_en = 1'b1; exm_rd = 5'd3; exm_result = 64'hAA;
    wb_wr_en  = 1'b1; wb_rd  = 5'd3; wb_result  = 64'hBB;
    #1 check("fwd exm", alu_a, 64'hAA);
    tick();
    exm_wr_en = 1'b0;
    #1 check("fwd wb", alu_a, 64'hBB);
    tick();
    set_instr(2'b10, SUB, 1'b0, 5'd31, 5'd4, 5'd9, 64'h33, 64'h22, 64'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    exm_wr_en = 1'b1; exm_rd = 5'd31; wb_rd = 5'd31;
    #1 check("fwd xzr", alu_a, 64'h33);
    tick();
    clear_wb();

    // Stall with a waiting instruction, then release
    set_instr(2'b10, AND, 1'b0, 5'd1, 5'd2, 5'd10, 64'hF0, 64'h3C, 64'd0);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    set_instr(2'b10, ORR, 1'b0, 5'd1, 5'd2, 5'd11, 64'h0F, 64'hC3, 64'd0);
    repeat (3) tick();
    check("stall ex_rd", ex_rd, 5'd10);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("release ex_rd", ex_rd, 5'd11);
    tick();

    // Flush beats a simultaneous capture; then an illegal opcode
    set_instr(2'b01, '0, 1'b0, 5'd1, 5'd2, 5'd12, 64'd1, 64'd2, 64'd0);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    set_instr(2'b10, ADD, 1'b0, 5'd1, 5'd2, 5'd13, 64'd1, 64'd2, 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush out_valid", out_valid, 1'b0);
    check("flush illegal", illegal, 1'b0);
    set_instr(2'b10, 11'h7FF, 1'b0, 5'd1, 5'd2, 5'd14, 64'd1, 64'd2, 64'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bad alu_sel", alu_sel, 4'b1111);
    check("bad illegal", illegal, 1'b1);
    tick();

    // Asynchronous reset in the middle of a stall
    set_instr(2'b10, SUB, 1'b0, 5'd1, 5'd2, 5'd15, 64'd9, 64'd4, 64'd0);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    q.delete();
    m_full = 1'b0;
    check("arst out_valid", out_valid, 1'b0);
    check("arst alu_sel", alu_sel, 4'b0000);
    check("arst alu_a", alu_a, '0);
    tick();
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_instr(2'($urandom), pick_opc(), 1'($urandom), pick_reg(), pick_reg(), 5'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 19) == 0);
      exm_wr_en  = 1'($urandom); exm_rd = pick_reg(); exm_result = {$urandom, $urandom};
      wb_wr_en   = 1'($urandom); wb_rd  = pick_reg(); wb_result  = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline stage that sits directly upstream of the 64-bit ALU. Registers decoded instruction fields, translates ALUOp plus the LEGv8 R-type opcode into the 4-bit ALU select (0000 AND, 0001 OR, 0010 ADD, 0110 SUB), resolves EX/MEM and MEM/WB forwarding, and presents final A/B operands. Provides valid/ready handshaking with stall and flush.

## Interface
- WIDTH, 64, datapath width of operands, immediate and forwarded results
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decode stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- alu_op  in  2  00 mem-address add, 01 branch compare, 10 R-type, 11 reserved
- opcode  in  11  R-type opcode field
- alu_src  in  1  1 selects immediate for B
- rs1, rs2, rd  in  5 each  register addresses
- rs1_data, rs2_data, imm  in  WIDTH each  register-file read data, sign-extended immediate
- flush  in  1  squash the held instruction
- out_ready  in  1  downstream EX/MEM accepts
- exm_wr_en, exm_rd, exm_result  in  1/5/WIDTH  EX/MEM writeback candidate
- wb_wr_en, wb_rd, wb_result  in  1/5/WIDTH  MEM/WB writeback candidate
- out_valid  out  1  alu_a/alu_b/alu_sel are valid
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_sel  out  4  ALU operation select
- store_data  out  WIDTH  forwarded rs2 value (for stores)
- ex_rd  out  5  destination register carried forward
- illegal  out  1  held instruction has no legal ALU mapping

## Operation
- Registered fields: valid, alu_sel, alu_src, rs1, rs2, rd, rs1_data, rs2_data, imm, illegal.
- Decode at capture: alu_op 00 -> 0010; 01 -> 0110; 10 with opcode 10001011000 -> 0010 (ADD), 11001011000 -> 0110 (SUB), 10001010000 -> 0000 (AND), 10101010000 -> 0001 (ORR); any other opcode or alu_op 11 -> alu_sel 1111, illegal 1.
- Forwarding (combinational on held fields): for operand rsX, if exm_wr_en and exm_rd==rsX and rsX!=31 use exm_result; else if wb_wr_en and wb_rd==rsX and rsX!=31 use wb_result; else held data. EX/MEM wins when both match.
- Register 31 (XZR) never forwarded; held data passes unchanged.
- alu_a = forwarded rs1; store_data = forwarded rs2; alu_b = imm if alu_src else forwarded rs2.
- States: EMPTY (out_valid 0), FULL (out_valid 1). EMPTY->FULL on capture; FULL->EMPTY on out_ready without capture, or flush; FULL->FULL on out_ready with capture; FULL holds while out_ready 0.

## Timing
- in_ready = !out_valid || out_ready (combinational, no dependence on in_valid).
- Capture on rising edge when in_valid && in_ready; latency one cycle to out_valid.
- Held fields stable while out_valid && !out_ready; forwarded operands may change as writeback inputs change.
- flush has priority over capture: next cycle out_valid 0, illegal 0, incoming instruction dropped.
- Illegal instructions still produce out_valid 1; consumer decides trap/ignore.
- Reset (rst_n low, any time incl. mid-stall): out_valid 0, all held fields 0, alu_sel 0000, illegal 0, ex_rd 0; alu_a/alu_b/store_data 0 unless a forwarding match on address 0 applies. Release takes effect at next edge.
- Arithmetic: no width change; all data WIDTH bits, no sign handling inside stage.

## Test plan
- Reset then R-type ADD (alu_op 10, opcode 10001011000, rs1_data 5, rs2_data 7, no forwarding) -> one cycle later out_valid 1, alu_sel 0010, alu_a 5, alu_b 7.
- Load with alu_src 1, imm 0xFFFF_FFFF_FFFF_FFF8, rs1_data 0x100 -> alu_sel 0010, alu_b 0xFFFF_FFFF_FFFF_FFF8, alu_a 0x100.
- Held SUB rs1=3, exm_wr_en 1 exm_rd 3 exm_result 0xAA, wb_wr_en 1 wb_rd 3 wb_result 0xBB -> alu_a 0xAA; drop exm_wr_en -> alu_a 0xBB; rs1=31 with matches -> alu_a = held rs1_data.
- out_ready 0 for 3 cycles with in_valid 1 -> in_ready 0, outputs unchanged; out_ready 1 -> new instruction appears next cycle, no loss or duplication.
- flush and in_valid asserted together while FULL -> next cycle out_valid 0; alu_op 10 opcode 11111111111 -> alu_sel 1111, illegal 1.
- rst_n low mid-stall while FULL -> out_valid 0, alu_sel 0000 immediately, before next clock edge.
